bkp_uart_rx: RTL and testbench
==============================

Name: bkp_uart_rx

Overview:
- Serial receiver that turns the BKP configuration UART line into byte strobes.
- Sits directly upstream of the slip2d motion controller, which consumes `BKPuart_ready_o` and `BKPuart_data_o` as its `BKPuart_ready_i` and `BKPuart_data_i` command inputs.
- Frame format is 8N1, LSB first, idle-high line.
- Includes start-bit glitch rejection, stop-bit framing check and break recovery.

Parameters:
- `sys_freq`, 50_000_000, system clock frequency in Hz.
- `baud`, 115_200, line rate in bit/s.
- `DIV` is a localparam equal to `sys_freq/baud`, truncated. It must be 4 or more; this is checked at elaboration.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  synchronous active-high reset.
- `rx_i`  in  1  asynchronous UART line, idle high.
- `BKPuart_ready_o`  out  1  one-cycle strobe, asserted when `BKPuart_data_o` holds a newly received valid byte.
- `BKPuart_data_o`  out  8  last valid byte received; held between strobes.
- `frame_err_o`  out  1  one-cycle strobe when a stop bit is sampled low.
- `busy_o`  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- **Reset:** synchronous on `rst`=1 at a `clk` edge. All outputs go to 0. The FSM goes to IDLE. The synchronizer stages load 1.
  - A reset that arrives mid-frame abandons the frame with no strobe.
  - After reset, the FSM returns to normal reception as described under IDLE.
- **Input synchronizer:** `rx_i` passes through a 2-FF synchronizer, giving `rx_s`. A third register holds the previous `rx_s` for falling-edge detection.
- **Baud counter:** 16 bits. It is cleared on every state entry and counts up to its terminal value, then clears.
- **IDLE:**
  - On a falling edge of `rx_s` (previous 1, current 0), go to START with the counter at 0.
  - If `rx_s` is already low when IDLE is entered, do not start a frame; wait for a genuine falling edge.
- **START:**
  - When the counter reaches `DIV/2 - 1`, sample `rx_s`.
  - If the sample is 1, it was a glitch: return to IDLE with no strobe.
  - If the sample is 0, go to DATA with bit index 0.
- **DATA:**
  - Sample every `DIV` cycles. Samples therefore land mid-bit, at `DIV/2 + k*DIV` cycles after the edge for k=1..8.
  - Shift the sample into bit [index] of the shift register (LSB first).
  - After index 7, go to STOP (or to PARITY when the optional feature is enabled).
- **STOP:** sample after `DIV` cycles.
  - If the sample is 1: load `BKPuart_data_o` from the shift register and pulse `BKPuart_ready_o` for exactly 1 cycle, on the cycle after the sample. Then go to IDLE.
  - If the sample is 0: pulse `frame_err_o` for 1 cycle. `BKPuart_data_o` is unchanged and there is no ready strobe. Go to BREAK.
- **BREAK:** stay until `rx_s`=1 for `DIV` consecutive cycles, then go to IDLE. A low cycle restarts the count.
- **Back-to-back frames:** a new start edge is accepted on the first cycle back in IDLE. The STOP sample occurs mid stop-bit, so the next start edge arrives at least `DIV/2` cycles later and is never missed.
- **Latency:** `BKPuart_ready_o` rises `DIV/2 + 9*DIV + 1` cycles (±2 for the synchronizer) after the falling edge of `rx_i`.
- `BKPuart_ready_o` and `frame_err_o` are never both high in the same cycle.
- `busy_o` is registered: it is 1 in START, DATA, STOP, PARITY and BREAK.

Optional Feature:
- Macro `BKP_UART_PARITY_EN`, when defined:
  - The frame is 8E1. A PARITY state is inserted after DATA and samples `DIV` cycles after bit 7.
  - Adds output port `parity_err_o` (1 bit, reset 0).
  - If the XOR of the 8 data bits and the parity bit is 1, the byte is dropped: `parity_err_o` pulses 1 cycle after the STOP sample and there is no ready strobe. The stop-bit check still applies; a framing error takes priority and suppresses `parity_err_o`.
  - Latency grows by `DIV`.
- When not defined: no PARITY state, no `parity_err_o` port, behaviour is 8N1 as above.

Test Plan:
- sys_freq=1_000_000, baud=100_000 (DIV=10). Send 0x11 8N1 → exactly one `BKPuart_ready_o` pulse with `BKPuart_data_o`=0x11, at 96±2 cycles after the start edge. `busy_o` is high for the frame and returns low.
- Send 0x13, 0x16, 0x20 back-to-back with no idle gap → three strobes carrying 0x13, 0x16, 0x20 in order. `frame_err_o` stays 0 throughout.
- Drive `rx_i` low for 3 cycles, then high → FSM returns to IDLE with no strobe, no error, and `BKPuart_data_o` unchanged.
- Send 0x12 with the stop bit forced low, then hold the line low for 50 cycles, then high → one `frame_err_o` pulse and no ready. `busy_o` stays 1 until 10 high cycles have elapsed. A following 0x14 is then received correctly.
- Assert `rst` for 1 cycle at data bit 4 of 0x15 → all outputs 0 on the next cycle and no strobe for that frame. A following 0x15 is received as 0x15.
- With `BKP_UART_PARITY_EN` defined: send 0x11 with correct even parity → strobe with 0x11. Send 0x11 with a wrong parity bit → one `parity_err_o` pulse and no ready.

Source files
------------

// File: rtl/bkp_uart_rx.sv
// bkp_uart_rx
// ----------------------------------------------------------------------------
// Receives the BKP configuration UART line and produces one-cycle byte strobes
// for the slip2d motion controller. The line format is 8N1, LSB first, with an
// idle-high line. The receiver rejects short start-bit glitches, checks the
// stop bit, and waits out a held-low line (break) before accepting new frames.
//
// Optional build macro:
//   BKP_UART_PARITY_EN  - receive 8E1 frames, with a PARITY state after DATA
//                         and an extra parity_err_o strobe.
//
// Parameters:
//   sys_freq  system clock frequency in Hz
//   baud      line rate in bit/s (DIV = sys_freq/baud, must be >= 4)
//
// Ports:
//   clk              system clock, rising edge
//   rst              synchronous active-high reset
//   rx_i             asynchronous UART line, idle high
//   BKPuart_ready_o  one-cycle strobe, BKPuart_data_o holds a new valid byte
//   BKPuart_data_o   last valid byte received, held between strobes
//   frame_err_o      one-cycle strobe when the stop bit is sampled low
//   parity_err_o     (parity build only) one-cycle strobe on an even-parity error
//   busy_o           high whenever the receiver is not idle
// ----------------------------------------------------------------------------
module bkp_uart_rx #(
  parameter int sys_freq = 50_000_000,
  parameter int baud     = 115_200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_i,
  output logic       BKPuart_ready_o,
  output logic [7:0] BKPuart_data_o,
  output logic       frame_err_o,
`ifdef BKP_UART_PARITY_EN
  output logic       parity_err_o,
`endif
  output logic       busy_o
);

  localparam int DIV = sys_freq / baud;

  // Terminal counts: the start bit is checked at its midpoint, every later bit
  // one full bit period after the previous sample, so samples stay mid-bit.
  localparam logic [15:0] HALF_TC = 16'(DIV / 2 - 1);
  localparam logic [15:0] FULL_TC = 16'(DIV - 1);

  generate
    if (DIV < 4) begin : g_div_check
      $error("bkp_uart_rx: sys_freq/baud must be at least 4");
    end
  endgenerate

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef BKP_UART_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP,
    ST_BREAK
  } state_t;

  state_t      state, state_next;
  logic [15:0] cnt, cnt_next;
  logic [2:0]  bit_idx, idx_next;
  logic [7:0]  shreg, shreg_next;
  logic        ready_next;
  logic        ferr_next;
  logic        rx_meta, rx_s, rx_prev;
`ifdef BKP_UART_PARITY_EN
  logic        par_bit, par_next;
  logic        perr_next;
`endif

  // Two-stage synchronizer plus a history stage for falling-edge detection.
  // Loading ones on reset makes the line look idle, so no frame starts until
  // the synchronized line is actually seen going low.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx_i;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  // State register and registered outputs. busy_o follows the next state so it
  // is high exactly while the registered state is not IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= ST_IDLE;
      cnt             <= '0;
      bit_idx         <= '0;
      shreg           <= '0;
      BKPuart_ready_o <= 1'b0;
      BKPuart_data_o  <= '0;
      frame_err_o     <= 1'b0;
      busy_o          <= 1'b0;
`ifdef BKP_UART_PARITY_EN
      par_bit         <= 1'b0;
      parity_err_o    <= 1'b0;
`endif
    end else begin
      state           <= state_next;
      cnt             <= cnt_next;
      bit_idx         <= idx_next;
      shreg           <= shreg_next;
      BKPuart_ready_o <= ready_next;
      frame_err_o     <= ferr_next;
      busy_o          <= (state_next != ST_IDLE);
      if (ready_next) begin
        BKPuart_data_o <= shreg;
      end
`ifdef BKP_UART_PARITY_EN
      par_bit         <= par_next;
      parity_err_o    <= perr_next;
`endif
    end
  end

  // Next-state logic. The counter restarts at zero whenever a state is entered
  // and whenever it reaches its terminal count within a state.
  always_comb begin
    state_next = state;
    cnt_next   = cnt + 16'd1;
    idx_next   = bit_idx;
    shreg_next = shreg;
    ready_next = 1'b0;
    ferr_next  = 1'b0;
`ifdef BKP_UART_PARITY_EN
    par_next   = par_bit;
    perr_next  = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        cnt_next = '0;
        if (rx_prev && !rx_s) begin
          state_next = ST_START;
        end
      end
      ST_START: begin
        if (cnt == HALF_TC) begin
          cnt_next = '0;
          if (rx_s) begin
            state_next = ST_IDLE;
          end else begin
            state_next = ST_DATA;
            idx_next   = 3'd0;
          end
        end
      end
      ST_DATA: begin
        if (cnt == FULL_TC) begin
          cnt_next            = '0;
          shreg_next[bit_idx] = rx_s;
          if (bit_idx == 3'd7) begin
`ifdef BKP_UART_PARITY_EN
            state_next = ST_PARITY;
`else
            state_next = ST_STOP;
`endif
          end else begin
            idx_next = bit_idx + 3'd1;
          end
        end
      end
`ifdef BKP_UART_PARITY_EN
      ST_PARITY: begin
        if (cnt == FULL_TC) begin
          cnt_next   = '0;
          par_next   = rx_s;
          state_next = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (cnt == FULL_TC) begin
          cnt_next = '0;
          if (rx_s) begin
            state_next = ST_IDLE;
`ifdef BKP_UART_PARITY_EN
            // Even parity: data bits plus parity bit must XOR to zero.
            if (^{shreg, par_bit}) begin
              perr_next = 1'b1;
            end else begin
              ready_next = 1'b1;
            end
`else
            ready_next = 1'b1;
`endif
          end else begin
            ferr_next  = 1'b1;
            state_next = ST_BREAK;
          end
        end
      end
      ST_BREAK: begin
        // Only a full bit period of continuous idle line ends the break.
        if (!rx_s) begin
          cnt_next = '0;
        end else if (cnt == FULL_TC) begin
          cnt_next   = '0;
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_bkp_uart_rx.sv
// tb_bkp_uart_rx
// ----------------------------------------------------------------------------
// Directed bench for bkp_uart_rx at sys_freq=1 MHz, baud=100 kbit/s (DIV=10).
// Frames are driven on rx_i from the falling clock edge; a monitor on the
// falling edge counts strobes and busy cycles and logs received bytes.
// Define BKP_UART_PARITY_EN for both files to exercise the 8E1 build.
// ----------------------------------------------------------------------------
module tb_bkp_uart_rx;

  localparam int DIV = 10;
`ifdef BKP_UART_PARITY_EN
  localparam int PAR_EXTRA = DIV;
`else
  localparam int PAR_EXTRA = 0;
`endif

  logic       clk;
  logic       rst;
  logic       rx_i;
  logic       BKPuart_ready_o;
  logic [7:0] BKPuart_data_o;
  logic       frame_err_o;
  logic       busy_o;
`ifdef BKP_UART_PARITY_EN
  logic       parity_err_o;
  logic       par_flip;
  int         perr_cnt;
`endif

  int         checks;
  int         failures;
  int         cyc;
  int         ready_cnt;
  int         ferr_cnt;
  int         busy_cyc;
  int         overlap_cnt;
  int         last_ready_cyc;
  int         edge_cyc;
  logic [7:0] rx_log [0:63];

  bkp_uart_rx #(
    .sys_freq(1_000_000),
    .baud    (100_000)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .rx_i           (rx_i),
    .BKPuart_ready_o(BKPuart_ready_o),
    .BKPuart_data_o (BKPuart_data_o),
    .frame_err_o    (frame_err_o),
`ifdef BKP_UART_PARITY_EN
    .parity_err_o   (parity_err_o),
`endif
    .busy_o         (busy_o)
  );

  // Free-running clock, 10 time units per cycle.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Rising-edge cycle counter used for latency measurement.
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Falling-edge monitor: counts strobes and busy cycles, logs received bytes.
  initial begin
    ready_cnt      = 0;
    ferr_cnt       = 0;
    busy_cyc       = 0;
    overlap_cnt    = 0;
    last_ready_cyc = 0;
`ifdef BKP_UART_PARITY_EN
    perr_cnt       = 0;
`endif
  end
  always @(negedge clk) begin
    if (!rst) begin
      if (BKPuart_ready_o === 1'b1) begin
        if (ready_cnt < 64) rx_log[ready_cnt] <= BKPuart_data_o;
        ready_cnt      <= ready_cnt + 1;
        last_ready_cyc <= cyc;
      end
      if (frame_err_o === 1'b1) ferr_cnt <= ferr_cnt + 1;
      if (BKPuart_ready_o === 1'b1 && frame_err_o === 1'b1) overlap_cnt <= overlap_cnt + 1;
      if (busy_o === 1'b1) busy_cyc <= busy_cyc + 1;
`ifdef BKP_UART_PARITY_EN
      if (parity_err_o === 1'b1) perr_cnt <= perr_cnt + 1;
`endif
    end
  end

  // One comparison: counts it, and reports observed/expected on a miss.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic sendBit(input logic v);
    rx_i = v;
    repeat (DIV) @(negedge clk);
  endtask

  // Drives one full frame starting on a falling clock edge. edge_cyc marks the
  // first rising edge that samples the low start bit.
  task automatic applyStimulus(input logic [7:0] b, input logic stop_bit);
    edge_cyc = cyc + 1;
    sendBit(1'b0);
    for (int i = 0; i < 8; i++) sendBit(b[i]);
`ifdef BKP_UART_PARITY_EN
    sendBit((^b) ^ par_flip);
`endif
    sendBit(stop_bit);
  endtask

  initial begin
    int r0;
    int f0;
    int b0;
    int lat;
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    rx_i     = 1'b1;
`ifdef BKP_UART_PARITY_EN
    par_flip = 1'b0;
`endif
    $display("[TB] start, DIV=%0d", DIV);

    // Reset state
    idle(3);
    checkOutput("rst_ready", 32'(BKPuart_ready_o), 32'd0);
    checkOutput("rst_data",  32'(BKPuart_data_o),  32'h00);
    checkOutput("rst_ferr",  32'(frame_err_o),     32'd0);
    checkOutput("rst_busy",  32'(busy_o),          32'd0);
    rst = 1'b0;
    idle(5);

    // Single frame 0x11: one strobe, latency 97 (window 96 +/- 2), busy 95 cycles
    r0 = ready_cnt;
    b0 = busy_cyc;
    applyStimulus(8'h11, 1'b1);
    idle(5);
    lat = last_ready_cyc - edge_cyc;
    checkOutput("single_count", 32'(ready_cnt - r0), 32'd1);
    checkOutput("single_log",   32'(rx_log[r0]),     32'h11);
    checkOutput("single_data",  32'(BKPuart_data_o), 32'h11);
    checkOutput("single_latency_in_window",
                32'((lat >= 94 + PAR_EXTRA) && (lat <= 98 + PAR_EXTRA)), 32'd1);
    checkOutput("single_busy_cycles", 32'(busy_cyc - b0), 32'(95 + PAR_EXTRA));
    checkOutput("single_busy_after",  32'(busy_o), 32'd0);

    // Back-to-back 0x13, 0x16, 0x20 with no idle gap
    r0 = ready_cnt;
    f0 = ferr_cnt;
    applyStimulus(8'h13, 1'b1);
    applyStimulus(8'h16, 1'b1);
    applyStimulus(8'h20, 1'b1);
    idle(5);
    checkOutput("b2b_count", 32'(ready_cnt - r0), 32'd3);
    checkOutput("b2b_byte0", 32'(rx_log[r0]),     32'h13);
    checkOutput("b2b_byte1", 32'(rx_log[r0 + 1]), 32'h16);
    checkOutput("b2b_byte2", 32'(rx_log[r0 + 2]), 32'h20);
    checkOutput("b2b_ferr",  32'(ferr_cnt - f0),  32'd0);

    // Start glitch of 3 cycles: enters START, rejected at the half-bit check
    r0 = ready_cnt;
    f0 = ferr_cnt;
    b0 = busy_cyc;
    rx_i = 1'b0;
    idle(3);
    rx_i = 1'b1;
    idle(20);
    checkOutput("glitch_ready",       32'(ready_cnt - r0), 32'd0);
    checkOutput("glitch_ferr",        32'(ferr_cnt - f0),  32'd0);
    checkOutput("glitch_data",        32'(BKPuart_data_o), 32'h20);
    checkOutput("glitch_busy_cycles", 32'(busy_cyc - b0),  32'd5);
    checkOutput("glitch_busy_after",  32'(busy_o),         32'd0);

    // 0x12 with stop bit low, line held low 50 more cycles, then released
    r0 = ready_cnt;
    f0 = ferr_cnt;
    b0 = busy_cyc;
    applyStimulus(8'h12, 1'b0);
    idle(50);
    rx_i = 1'b1;
    idle(9);
    checkOutput("break_busy_held", 32'(busy_o), 32'd1);
    idle(4);
    checkOutput("break_busy_released", 32'(busy_o), 32'd0);
    checkOutput("break_ferr",          32'(ferr_cnt - f0),  32'd1);
    checkOutput("break_ready",         32'(ready_cnt - r0), 32'd0);
    checkOutput("break_data",          32'(BKPuart_data_o), 32'h20);
    checkOutput("break_busy_cycles",   32'(busy_cyc - b0),  32'(159 + PAR_EXTRA));
    r0 = ready_cnt;
    applyStimulus(8'h14, 1'b1);
    idle(5);
    checkOutput("after_break_count", 32'(ready_cnt - r0), 32'd1);
    checkOutput("after_break_data",  32'(BKPuart_data_o), 32'h14);

    // Reset during data bit 4 of 0x15, then a clean 0x15
    r0 = ready_cnt;
    sendBit(1'b0);
    for (int i = 0; i < 4; i++) sendBit(((8'h15 >> i) & 8'h01) != 8'h00);
    rx_i = 1'b1;
    idle(5);
    rst = 1'b1;
    idle(1);
    checkOutput("midrst_ready", 32'(BKPuart_ready_o), 32'd0);
    checkOutput("midrst_data",  32'(BKPuart_data_o),  32'h00);
    checkOutput("midrst_ferr",  32'(frame_err_o),     32'd0);
    checkOutput("midrst_busy",  32'(busy_o),          32'd0);
    rst = 1'b0;
    idle(120);
    checkOutput("midrst_no_strobe", 32'(ready_cnt - r0), 32'd0);
    applyStimulus(8'h15, 1'b1);
    idle(5);
    checkOutput("postrst_count", 32'(ready_cnt - r0), 32'd1);
    checkOutput("postrst_data",  32'(BKPuart_data_o), 32'h15);

`ifdef BKP_UART_PARITY_EN
    // Even parity: correct parity accepted, flipped parity dropped
    r0 = ready_cnt;
    f0 = perr_cnt;
    par_flip = 1'b0;
    applyStimulus(8'h11, 1'b1);
    idle(5);
    checkOutput("par_ok_count", 32'(ready_cnt - r0), 32'd1);
    checkOutput("par_ok_data",  32'(BKPuart_data_o), 32'h11);
    checkOutput("par_ok_perr",  32'(perr_cnt - f0),  32'd0);
    r0 = ready_cnt;
    f0 = perr_cnt;
    par_flip = 1'b1;
    applyStimulus(8'h11, 1'b1);
    idle(5);
    par_flip = 1'b0;
    checkOutput("par_bad_perr",  32'(perr_cnt - f0),  32'd1);
    checkOutput("par_bad_ready", 32'(ready_cnt - r0), 32'd0);
`endif

    checkOutput("ready_ferr_overlap", 32'(overlap_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
